// File: rtl/led_pwm_fader.sv
// LED PWM fader: gates an LED data pattern with a PWM whose brightness
// ramps up and down ("breathes") one step per CE tick. Duty cycle and data
// are shadowed at PWM period boundaries so the outputs never glitch
// mid-period.
module led_pwm_fader #(
   parameter int WIDTH    = 8,  // LED data bits
   parameter int PWM_BITS = 8,  // PWM phase / brightness resolution
   parameter int STEP     = 1   // brightness step per CE tick, 1..2^PWM_BITS-1
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [WIDTH-1:0]    I,
   input  logic                CE,
   output logic [WIDTH-1:0]    O,
   output logic [PWM_BITS-1:0] LEVEL,
   output logic                PERIOD
);

   // Ramp direction encoding.
   localparam logic [0:0] ST_RISE = 1'b0;
   localparam logic [0:0] ST_FALL = 1'b1;

   localparam logic [PWM_BITS-1:0] MAX    = '1;
   localparam logic [PWM_BITS-1:0] ONE    = PWM_BITS'(1);
   localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(STEP);
   // At or above this level one more rising step would pass MAX.
   localparam logic [PWM_BITS-1:0] RISE_LIMIT = MAX - STEP_V;

   // Free-running PWM phase counter.
   logic [PWM_BITS-1:0] phase_q, phase_d;
   // Brightness ramp.
   logic [PWM_BITS-1:0] level_q, level_d;
   logic [0:0]          state_q, state_d;
   // Period-boundary shadow registers.
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [WIDTH-1:0]    data_q, data_d;
   // Registered LED outputs.
   logic [WIDTH-1:0]    o_q, o_d;

   logic boundary;

   // Last phase of the PWM period; shadow registers load on this edge.
   assign boundary = (phase_q == MAX);

   // Phase counter advances every cycle and wraps naturally at MAX.
   always_comb begin
      phase_d = phase_q + ONE;
   end

   // Ramp next-state: saturating step up in RISE, down in FALL, CE-gated.
   always_comb begin
      // NOTE: defaults first so every path assigns the outputs; otherwise
      // the hold case would infer a latch.
      level_d = level_q;
      state_d = state_q;
      if (CE) begin
         if (state_q == ST_RISE) begin
            if (level_q >= RISE_LIMIT) begin
               level_d = MAX;
               state_d = ST_FALL;
            end else begin
               level_d = level_q + STEP_V;
            end
         end else begin
            if (level_q <= STEP_V) begin
               level_d = '0;
               state_d = ST_RISE;
            end else begin
               level_d = level_q - STEP_V;
            end
         end
      end
   end

   // Shadow load: capture the pre-update level and the data at the boundary.
   always_comb begin
      duty_d = duty_q;
      data_d = data_q;
      if (boundary) begin
         duty_d = level_q;
         data_d = I;
      end
   end

   // PWM compare: data bits are on while phase is below the shadowed duty.
   always_comb begin
      o_d = (phase_q < duty_q) ? data_q : '0;
   end

   // All state registers, cleared by the synchronous reset.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge (duty_q sees the old level on a CE boundary).
      if (RESET) begin
         phase_q <= '0;
         level_q <= '0;
         state_q <= ST_RISE;
         duty_q  <= '0;
         data_q  <= '0;
         o_q     <= '0;
      end else begin
         phase_q <= phase_d;
         level_q <= level_d;
         state_q <= state_d;
         duty_q  <= duty_d;
         data_q  <= data_d;
         o_q     <= o_d;
      end
   end

   assign O      = o_q;
   assign LEVEL  = level_q;
   assign PERIOD = boundary;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Testbench for led_pwm_fader: table-driven saturation vectors on a STEP=100
// instance plus hand-written sequences for reset, duty, ramp turn, shadowing
// and mid-operation reset on a default instance.
module tb_led_pwm_fader;

   logic       CLK;
   logic       RESET;
   logic [7:0] I;
   logic       CE;
   logic [7:0] O;
   logic [7:0] LEVEL;
   logic       PERIOD;

   logic       rst100;
   logic [7:0] i100;
   logic       ce100;
   logic [7:0] o100;
   logic [7:0] level100;
   logic       period100;

   int tests_run;
   int tests_failed;

   led_pwm_fader #(.WIDTH(8), .PWM_BITS(8), .STEP(1)) dut (
      .CLK(CLK), .RESET(RESET), .I(I), .CE(CE),
      .O(O), .LEVEL(LEVEL), .PERIOD(PERIOD)
   );

   led_pwm_fader #(.WIDTH(8), .PWM_BITS(8), .STEP(100)) dut100 (
      .CLK(CLK), .RESET(rst100), .I(i100), .CE(ce100),
      .O(o100), .LEVEL(level100), .PERIOD(period100)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Saturation vectors: inputs applied for one edge, then LEVEL compared.
   typedef struct packed {
      logic       rst;
      logic       ce;
      logic [7:0] exp_level;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one edge; sample point is 1 time unit after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ce_pulses(input int n);
      CE = 1'b1;
      repeat (n) tick();
      CE = 1'b0;
   endtask

   task automatic do_reset(input int n);
      RESET = 1'b1;
      repeat (n) tick();
      RESET = 1'b0;
   endtask

   // Waits (bounded) until PERIOD is high at the sample point.
   task automatic wait_period(input string name);
      int n;
      n = 0;
      while (!PERIOD && n < 300) begin
         tick();
         n++;
      end
      if (!PERIOD) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int cyc;
      int errs;
      int on_cnt;
      int errs_p [3];
      int on_p   [3];
      logic [7:0] exp_o;
      logic       period_seen;

      tests_run    = 0;
      tests_failed = 0;
      RESET = 1'b0; I = 8'h00; CE = 1'b0;
      rst100 = 1'b0; i100 = 8'h00; ce100 = 1'b0;

      // ---------------- Saturation, STEP=100 (table-driven) ----------------
      vecs[0] = '{rst: 1'b1, ce: 1'b1, exp_level: 8'd0};
      vecs[1] = '{rst: 1'b0, ce: 1'b1, exp_level: 8'd100};
      vecs[2] = '{rst: 1'b0, ce: 1'b1, exp_level: 8'd200};
      vecs[3] = '{rst: 1'b0, ce: 1'b1, exp_level: 8'd255};
      vecs[4] = '{rst: 1'b0, ce: 1'b1, exp_level: 8'd155};
      vecs[5] = '{rst: 1'b0, ce: 1'b0, exp_level: 8'd155};
      vecs[6] = '{rst: 1'b0, ce: 1'b1, exp_level: 8'd55};
      vecs[7] = '{rst: 1'b0, ce: 1'b1, exp_level: 8'd0};
      vecs[8] = '{rst: 1'b0, ce: 1'b1, exp_level: 8'd100};
      for (int v = 0; v < 9; v++) begin
         rst100 = vecs[v].rst;
         ce100  = vecs[v].ce;
         tick();
         check($sformatf("sat_vec%0d", v), {24'd0, level100}, {24'd0, vecs[v].exp_level});
      end
      rst100 = 1'b0;
      ce100  = 1'b0;

      // ---------------- 1. Reset ----------------
      I  = 8'hFF;
      CE = 1'b1;
      do_reset(2);
      check("reset_O", {24'd0, O}, 32'h00);
      check("reset_LEVEL", {24'd0, LEVEL}, 32'd0);
      check("reset_PERIOD", {31'd0, PERIOD}, 32'd0);
      CE  = 1'b0;
      cyc = 1;
      while (!PERIOD && cyc < 600) begin
         tick();
         cyc++;
      end
      check("first_period_cycle", cyc, 32'd256);
      repeat (255) tick();
      check("period_gap_low", {31'd0, PERIOD}, 32'd0);
      tick();
      check("period_repeat_high", {31'd0, PERIOD}, 32'd1);

      // ---------------- 2. Static duty 64 ----------------
      ce_pulses(64);
      check("duty_level64", {24'd0, LEVEL}, 32'd64);
      I = 8'hA5;
      wait_period("duty");
      tick();  // boundary edge loads duty/data
      tick();  // O now reflects phase 0
      errs   = 0;
      on_cnt = 0;
      for (int k = 0; k < 512; k++) begin
         exp_o = ((k % 256) < 64) ? 8'hA5 : 8'h00;
         if (O !== exp_o) errs++;
         if (O == 8'hA5) on_cnt++;
         tick();
      end
      check("duty_pattern_errs", errs, 32'd0);
      check("duty_on_cycles", on_cnt, 32'd128);

      // ---------------- 3. Ramp turn ----------------
      do_reset(2);
      ce_pulses(254);
      check("ramp_254", {24'd0, LEVEL}, 32'd254);
      ce_pulses(1);
      check("ramp_top_255", {24'd0, LEVEL}, 32'd255);
      ce_pulses(1);
      check("ramp_fall_254", {24'd0, LEVEL}, 32'd254);
      ce_pulses(254);
      check("ramp_bottom_0", {24'd0, LEVEL}, 32'd0);
      ce_pulses(1);
      check("ramp_rise_1", {24'd0, LEVEL}, 32'd1);

      // ---------------- 5. Shadowing ----------------
      do_reset(2);
      ce_pulses(128);
      check("shadow_level128", {24'd0, LEVEL}, 32'd128);
      I = 8'h0F;
      wait_period("shadow");
      tick();
      tick();
      period_seen = 1'b0;
      for (int p = 0; p < 3; p++) begin
         errs_p[p] = 0;
         on_p[p]   = 0;
      end
      for (int k = 0; k < 768; k++) begin
         int p;
         int j;
         p = k / 256;
         j = k % 256;
         if (p == 0)      exp_o = (j < 128) ? 8'h0F : 8'h00;
         else if (p == 1) exp_o = (j < 128) ? 8'hF0 : 8'h00;
         else             exp_o = (j < 129) ? 8'hF0 : 8'h00;
         if (O !== exp_o) errs_p[p]++;
         if (O != 8'h00) on_p[p]++;
         if (k == 9) I = 8'hF0;          // phase 10: mid-period data change
         if (k == 254) begin             // phase 255: CE on the boundary
            period_seen = PERIOD;
            CE = 1'b1;
         end
         if (k == 255) CE = 1'b0;
         tick();
      end
      check("shadow_period_align", {31'd0, period_seen}, 32'd1);
      check("shadow_p0_errs", errs_p[0], 32'd0);
      check("shadow_p1_errs", errs_p[1], 32'd0);
      check("shadow_p2_errs", errs_p[2], 32'd0);
      check("shadow_p1_on", on_p[1], 32'd128);
      check("shadow_p2_on", on_p[2], 32'd129);
      check("shadow_level129", {24'd0, LEVEL}, 32'd129);

      // ---------------- 6. Mid-operation reset ----------------
      do_reset(2);
      ce_pulses(255);
      ce_pulses(127);
      check("midrst_level128", {24'd0, LEVEL}, 32'd128);
      I = 8'hFF;
      do_reset(1);
      check("midrst_O", {24'd0, O}, 32'h00);
      check("midrst_LEVEL", {24'd0, LEVEL}, 32'd0);
      check("midrst_PERIOD", {31'd0, PERIOD}, 32'd0);
      cyc = 1;
      CE  = 1'b1;
      tick();
      cyc++;
      CE = 1'b0;
      check("midrst_rise_1", {24'd0, LEVEL}, 32'd1);
      on_cnt = 0;
      while (!PERIOD && cyc < 600) begin
         if (O != 8'h00) on_cnt++;
         tick();
         cyc++;
      end
      check("midrst_period_cycle", cyc, 32'd256);
      check("midrst_O_dark", on_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
